// File: rtl/lpm_and_seq_pkg.sv
// ============================================================================
// Module      : lpm_and_seq_pkg
// Description : Shared state encoding and helpers for the lpm_*_seq sequencers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lpm_and_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FOLD = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Ceiling log2; clog2(1) is 0, so callers needing a 1-bit minimum clamp it.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lpm_and_seq_and.sv
// ============================================================================
// Module      : lpm_and
// Description : Combinational AND reduction of lpm_size words of lpm_width bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lpm_and #(
  parameter int lpm_width = 8,
  parameter int lpm_size  = 2
) (
  input  logic [lpm_size*lpm_width-1:0] data,
  output logic [lpm_width-1:0]          result
);

  always_comb begin
    result = data[lpm_width-1:0];
    for (int j = 1; j < lpm_size; j++) begin
      result = result & data[j*lpm_width +: lpm_width];
    end
  end

endmodule

`default_nettype wire

// File: rtl/lpm_and_seq.sv
// ============================================================================
// Module      : lpm_and_seq
// Description : Multi-cycle AND reduction, one word per clock through a single
//               2-input AND slice, with valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lpm_and_seq
  import lpm_and_seq_pkg::*;
#(
  parameter string lpm_type  = "lpm_and_seq",
  parameter int    lpm_width = 8,
  parameter int    lpm_size  = 4,
  parameter string lpm_early = "OFF",
  parameter string lpm_hint  = "UNUSED"
) (
  input  logic                               clock,
  input  logic                               aclr_n,
  input  logic                               sclr,
  input  logic                               data_valid,
  output logic                               data_ready,
  input  logic [lpm_size*lpm_width-1:0]      data,
  output logic                               result_valid,
  input  logic                               result_ready,
  output logic [lpm_width-1:0]               result,
  output logic [clog2(lpm_size+1)-1:0]       count,
  output logic                               busy
);

  localparam int c_CW    = clog2(lpm_size + 1);
  localparam int c_IDXW  = (lpm_size > 1) ? clog2(lpm_size) : 1;
  localparam bit c_EARLY = (lpm_early == "ON");
  localparam logic [c_IDXW-1:0] c_LAST_IDX = c_IDXW'(lpm_size - 1);

  // Elaboration-only sanity hook; an illegal configuration leaves an empty marker scope.
  if (lpm_size < 1 || lpm_type != "lpm_and_seq" || lpm_hint == "") begin : g_bad_cfg
  end

  seq_state_e                    state_q, state_d;
  logic [lpm_size*lpm_width-1:0] shadow_q, shadow_d;
  logic [lpm_width-1:0]          acc_q, acc_d;
  logic [c_IDXW-1:0]             idx_q, idx_d;
  logic [c_CW-1:0]               cnt_q, cnt_d;

  logic [lpm_width-1:0] w_word0;
  logic [lpm_width-1:0] w_word;
  logic [lpm_width-1:0] w_and;
  logic                 w_accept;

  assign w_word0 = data[lpm_width-1:0];

  always_comb begin
    w_word = '0;
    for (int j = 0; j < lpm_size; j++) begin
      if (idx_q == c_IDXW'(j)) begin
        w_word = shadow_q[j*lpm_width +: lpm_width];
      end
    end
  end

  lpm_and #(
    .lpm_width (lpm_width),
    .lpm_size  (2)
  ) u_and (
    .data   ({w_word, acc_q}),
    .result (w_and)
  );

  assign data_ready   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && result_ready);
  assign w_accept     = data_valid && data_ready;
  assign result_valid = (state_q == ST_DONE);
  assign busy         = (state_q == ST_FOLD);
  assign result       = acc_q;
  assign count        = cnt_q;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A DONE-state accept retires the old result and starts the next on one edge.
        if (w_accept) begin
          shadow_d = data;
          acc_d    = w_word0;
          idx_d    = c_IDXW'(1);
          cnt_d    = c_CW'(1);
          if ((lpm_size == 1) || (c_EARLY && (w_word0 == '0))) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_FOLD;
          end
        end else if ((state_q == ST_DONE) && result_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_FOLD: begin
        acc_d = w_and;
        cnt_d = cnt_q + c_CW'(1);
        if ((idx_q == c_LAST_IDX) || (c_EARLY && (w_and == '0))) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + c_IDXW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else if (sclr) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

`default_nettype wire
